// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package wb_pkg;

  localparam int DefDataWidth  = 16;
  localparam int DefNumRegs    = 16;
  localparam int DefIndexWidth = $clog2(DefNumRegs);
  localparam int DefQueueDepth = 2;

  typedef struct packed {
    logic [DefIndexWidth-1:0] addr;
    logic [DefDataWidth-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular FIFO with a separate occupancy count so full and empty never alias.
// A push becomes visible at the head one cycle later; push when full and pop when empty are ignored.
module wb_queue
  import wb_pkg::*;
#(
  parameter type entry_t  = wb_entry_t,
  parameter int  Depth    = DefQueueDepth,
  parameter int  CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                push,
  input  entry_t              push_entry,
  input  logic                pop,
  output entry_t              head,
  output logic                full,
  output logic                empty,
  output logic [CntWidth-1:0] count
);

  localparam int                  PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] FullCnt  = CntWidth'(Depth);

  entry_t              mem [Depth];
  logic [PtrWidth-1:0] rd_ptr;
  logic [PtrWidth-1:0] wr_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == FullCnt);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrWidth'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrWidth'(1);
      if (do_push && !do_pop)      count <= count + CntWidth'(1);
      else if (do_pop && !do_push) count <= count - CntWidth'(1);
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU results (priority) and queued load results onto one registered write port; 1 cycle for ALU, 2 for loads.
// memReady drops when the load queue is full; WB_STARVE_GUARD_EN adds an aluStall that forces one load through.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DataWidth  = DefDataWidth,
  parameter int NumRegs    = DefNumRegs,
  parameter int IndexWidth = $clog2(NumRegs),
  parameter int QueueDepth = DefQueueDepth
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  aluValid,
  input  logic [IndexWidth-1:0] aluAddr,
  input  logic [DataWidth-1:0]  aluData,
  output logic                  aluStall,
  input  logic                  memValid,
  output logic                  memReady,
  input  logic [IndexWidth-1:0] memAddr,
  input  logic [DataWidth-1:0]  memData,
  input  logic                  issueValid,
  input  logic [IndexWidth-1:0] issueAddr,
  output logic [NumRegs-1:0]    busyMask,
  output logic                  writeEn,
  output logic [IndexWidth-1:0] writeAddr,
  output logic [DataWidth-1:0]  writeData
);

  localparam int                  CntWidth = $clog2(QueueDepth + 1);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(QueueDepth);

  typedef struct packed {
    logic [IndexWidth-1:0] addr;
    logic [DataWidth-1:0]  data;
  } entry_t;

  entry_t              push_entry;
  entry_t              head;
  logic                q_full;
  logic                q_empty;
  logic [CntWidth-1:0] q_count;
  logic                alu_win;
  logic                pop;
  logic [NumRegs-1:0]  busy_next;

  // Readiness depends only on occupancy so a same-cycle pop never opens a slot early.
  assign memReady   = (q_count < DepthCnt);
  assign alu_win    = aluValid && !aluStall;
  assign pop        = !alu_win && !q_empty;
  assign push_entry = '{addr: memAddr, data: memData};

  wb_queue #(
    .entry_t (entry_t),
    .Depth   (QueueDepth),
    .CntWidth(CntWidth)
  ) u_queue (
    .clk       (clk),
    .rstN      (rstN),
    .push      (memValid && memReady),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      writeEn   <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
    end else begin
      writeEn <= alu_win || pop;
      if (alu_win) begin
        writeAddr <= aluAddr;
        writeData <= aluData;
      end else if (pop) begin
        writeAddr <= head.addr;
        writeData <= head.data;
      end
    end
  end

  // A fresh issue to the register being retired wins: a newer load is still outstanding.
  always_comb begin
    busy_next = busyMask;
    if (pop)        busy_next[head.addr] = 1'b0;
    if (issueValid) busy_next[issueAddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) busyMask <= '0;
    else       busyMask <= busy_next;
  end

`ifdef WB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign aluStall = (starve_cnt == 3'd4);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                 starve_cnt <= '0;
    else if (aluStall)         starve_cnt <= '0;
    else if (alu_win && q_full) starve_cnt <= starve_cnt + 3'd1;
  end
`else
  assign aluStall = 1'b0;
`endif

`ifndef SYNTHESIS
  a_alu_waw: assert property (@(posedge clk) disable iff (!rstN) !(aluValid && busyMask[aluAddr]));
  a_q_flags: assert property (@(posedge clk) disable iff (!rstN) q_full == !memReady);
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a queue-based reference model checked every cycle.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        aluValid = 1'b0;
  logic [3:0]  aluAddr = '0;
  logic [15:0] aluData = '0;
  logic        aluStall;
  logic        memValid = 1'b0;
  logic        memReady;
  logic [3:0]  memAddr = '0;
  logic [15:0] memData = '0;
  logic        issueValid = 1'b0;
  logic [3:0]  issueAddr = '0;
  logic [15:0] busyMask;
  logic        writeEn;
  logic [3:0]  writeAddr;
  logic [15:0] writeData;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_arbiter dut (
    .clk       (clk),
    .rstN      (rstN),
    .aluValid  (aluValid),
    .aluAddr   (aluAddr),
    .aluData   (aluData),
    .aluStall  (aluStall),
    .memValid  (memValid),
    .memReady  (memReady),
    .memAddr   (memAddr),
    .memData   (memData),
    .issueValid(issueValid),
    .issueAddr (issueAddr),
    .busyMask  (busyMask),
    .writeEn   (writeEn),
    .writeAddr (writeAddr),
    .writeData (writeData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: plain queue of pending loads plus the write-port value due next cycle.
  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_busy = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_wa = '0;
  logic [15:0] m_wd = '0;
  int          m_streak = 0;
  logic        m_stall = 1'b0;

  initial begin
    int   pre;
    bit   win;
    ent_t e;
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        mq.delete();
        m_busy = '0; m_we = 1'b0; m_wa = '0; m_wd = '0;
        m_streak = 0; m_stall = 1'b0;
      end else begin
        pre = mq.size();
        win = aluValid && !m_stall;
        if (win) begin
          m_we = 1'b1; m_wa = aluAddr; m_wd = aluData;
        end else if (pre > 0) begin
          e = mq.pop_front();
          m_we = 1'b1; m_wa = e.addr; m_wd = e.data;
          m_busy[e.addr] = 1'b0;
        end else begin
          m_we = 1'b0;
        end
        if (issueValid) m_busy[issueAddr] = 1'b1;
        if (memValid && pre < DEPTH) mq.push_back('{memAddr, memData});
`ifdef WB_STARVE_GUARD_EN
        if (m_stall) m_streak = 0;
        else if (win && pre == DEPTH) m_streak++;
        m_stall = (m_streak == 4);
`else
        m_stall = 1'b0;
`endif
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstN) begin
        chk("cmp_writeEn", writeEn, m_we);
        chk("cmp_writeAddr", writeAddr, m_wa);
        chk("cmp_writeData", writeData, m_wd);
        chk("cmp_busyMask", busyMask, m_busy);
        chk("cmp_memReady", memReady, (mq.size() < DEPTH));
        chk("cmp_aluStall", aluStall, m_stall);
      end
    end
  end

  initial begin
    logic [15:0] d;
    logic        prev_stall;

    // Reset
    #1 rstN = 1'b0;
    repeat (2) tick();
    chk("rst_writeEn", writeEn, 0);
    chk("rst_busyMask", busyMask, 0);
    chk("rst_memReady", memReady, 1);
    chk("rst_aluStall", aluStall, 0);
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_writeEn", writeEn, 0);
      chk("idle_writeAddr", writeAddr, 0);
      chk("idle_writeData", writeData, 0);
      chk("idle_busyMask", busyMask, 0);
      chk("idle_memReady", memReady, 1);
    end

    // ALU only
    aluValid = 1'b1; aluAddr = 4'd3; aluData = 16'h1234;
    tick();
    aluValid = 1'b0; aluAddr = '0; aluData = '0;
    chk("alu_writeEn", writeEn, 1);
    chk("alu_writeAddr", writeAddr, 3);
    chk("alu_writeData", writeData, 16'h1234);
    tick();
    chk("alu_writeEn_drop", writeEn, 0);
    chk("alu_writeAddr_hold", writeAddr, 3);

    // Load path
    issueValid = 1'b1; issueAddr = 4'd5;
    tick();
    issueValid = 1'b0;
    chk("ld_busy_set", busyMask, 16'h0020);
    repeat (3) tick();
    chk("ld_ready", memReady, 1);
    memValid = 1'b1; memAddr = 4'd5; memData = 16'hBEEF;
    tick();
    memValid = 1'b0;
    chk("ld_n5_writeEn", writeEn, 0);
    chk("ld_n5_busy", busyMask, 16'h0020);
    tick();
    chk("ld_n6_writeEn", writeEn, 1);
    chk("ld_n6_writeAddr", writeAddr, 5);
    chk("ld_n6_writeData", writeData, 16'hBEEF);
    chk("ld_n6_busy", busyMask, 0);

    // Contention: four ALU cycles while two loads arrive
    for (int k = 0; k < 4; k++) begin
      aluValid = 1'b1; aluAddr = 4'(8 + k); aluData = 16'h1000 + 16'(k);
      memValid = (k < 2);
      memAddr  = (k == 0) ? 4'd1 : 4'd2;
      memData  = (k == 0) ? 16'hAAAA : 16'hBBBB;
      if (k == 1) chk("cont_ready_one", memReady, 1);
      if (k >= 2) chk("cont_ready_full", memReady, 0);
      tick();
    end
    aluValid = 1'b0; memValid = 1'b0;
    chk("cont_last_alu", writeAddr, 11);
    tick();
    chk("cont_ld1_writeEn", writeEn, 1);
    chk("cont_ld1_writeAddr", writeAddr, 1);
    chk("cont_ld1_writeData", writeData, 16'hAAAA);
    tick();
    chk("cont_ld2_writeAddr", writeAddr, 2);
    chk("cont_ld2_writeData", writeData, 16'hBBBB);
    tick();
    chk("cont_drain_writeEn", writeEn, 0);
    chk("cont_drain_ready", memReady, 1);

    // Set/clear collision on register 7
    issueValid = 1'b1; issueAddr = 4'd7;
    tick();
    issueValid = 1'b0;
    memValid = 1'b1; memAddr = 4'd7; memData = 16'h7777;
    chk("coll_busy_set", busyMask, 16'h0080);
    tick();
    memValid = 1'b0;
    issueValid = 1'b1; issueAddr = 4'd7;
    tick();
    issueValid = 1'b0;
    chk("coll_writeAddr", writeAddr, 7);
    chk("coll_writeData", writeData, 16'h7777);
    chk("coll_busy_kept", busyMask, 16'h0080);
    memValid = 1'b1; memAddr = 4'd7; memData = 16'h7878;
    tick();
    memValid = 1'b0;
    tick();
    chk("coll2_writeData", writeData, 16'h7878);
    chk("coll2_busy_clr", busyMask, 0);

    // Reset mid-operation discards the queued load
    issueValid = 1'b1; issueAddr = 4'd12;
    memValid = 1'b1; memAddr = 4'd12; memData = 16'hC0DE;
    aluValid = 1'b1; aluAddr = 4'd13; aluData = 16'h1313;
    tick();
    issueValid = 1'b0; memValid = 1'b0; aluData = 16'h1314;
    chk("mid_busy", busyMask, 16'h1000);
    #2 rstN = 1'b0;
    #1;
    chk("mid_rst_busy", busyMask, 0);
    chk("mid_rst_ready", memReady, 1);
    chk("mid_rst_writeEn", writeEn, 0);
    chk("mid_rst_writeAddr", writeAddr, 0);
    aluValid = 1'b0; aluAddr = '0; aluData = '0;
    tick();
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_after_writeEn", writeEn, 0);
      chk("mid_after_busy", busyMask, 0);
    end

    // Starvation: queue full while the ALU stays valid
    d = 16'h0A00;
    prev_stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0 && !prev_stall) d = d + 16'd1;
      aluValid = 1'b1; aluAddr = 4'd0; aluData = d;
      memValid = (k < 2);
      memAddr  = (k == 0) ? 4'd14 : 4'd15;
      memData  = (k == 0) ? 16'hE0E0 : 16'hF0F0;
      if (k == 2) chk("stv_full", memReady, 0);
`ifdef WB_STARVE_GUARD_EN
      if (k == 5) chk("stv_no_stall_yet", aluStall, 0);
      if (k == 6) chk("stv_stall", aluStall, 1);
      if (k == 7) begin
        chk("stv_pop_writeAddr", writeAddr, 14);
        chk("stv_pop_writeData", writeData, 16'hE0E0);
        chk("stv_stall_drop", aluStall, 0);
      end
      if (k == 8) chk("stv_held_alu", writeData, 16'h0A06);
`else
      chk("stv_stall_off", aluStall, 0);
      if (k == 7) chk("stv_alu_s6", writeData, 16'h0A06);
      if (k == 8) chk("stv_alu_s7", writeData, 16'h0A07);
`endif
      prev_stall = aluStall;
      tick();
    end
    aluValid = 1'b0; memValid = 1'b0;
    tick();
`ifdef WB_STARVE_GUARD_EN
    chk("stv_drain_writeAddr", writeAddr, 15);
    chk("stv_drain_writeData", writeData, 16'hF0F0);
`else
    chk("stv_drain1_writeAddr", writeAddr, 14);
    chk("stv_drain1_writeData", writeData, 16'hE0E0);
    tick();
    chk("stv_drain2_writeAddr", writeAddr, 15);
    chk("stv_drain2_writeData", writeData, 16'hF0F0);
`endif
    repeat (3) tick();
    chk("end_ready", memReady, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

- Merges single-cycle ALU results and variable-latency memory load results onto the register file's single write port (writeEn/writeAddr/writeData).
- Buffers load results in a small queue with a valid/ready handshake.
- Keeps a pending-load scoreboard so decode can stall on registers whose load has not yet returned.
- Sits between the execute/memory stages and the register file, and drives its write port directly from flops.

## Interface
- DataWidth, 16, register data width
- NumRegs, 16, number of architectural registers
- IndexWidth, $clog2(NumRegs), register index width
- QueueDepth, 2, load result queue entries (≥1)

Ports:
- clk  in  1  clock
- rstN  in  1  reset, asynchronous, active-low
- aluValid  in  1  ALU result present this cycle
- aluAddr  in  IndexWidth  ALU destination
- aluData  in  DataWidth  ALU result
- aluStall  out  1  ALU must hold its result (see Configuration)
- memValid  in  1  load result offered
- memReady  out  1  queue can accept
- memAddr  in  IndexWidth  load destination
- memData  in  DataWidth  load data
- issueValid  in  1  load issued this cycle, mark destination pending
- issueAddr  in  IndexWidth  destination of issued load
- busyMask  out  NumRegs  bit i set = register i awaits a load
- writeEn, writeAddr, writeData  out  1/IndexWidth/DataWidth  register file write port, registered

## Operation
- One clock domain. Reset is asynchronous and active-low. Reset forces:
  - writeEn=0, writeAddr=0, writeData=0
  - busyMask=0, aluStall=0
  - queue empty, so memReady=1
- Load accept: memValid && memReady pushes {memAddr, memData}. memReady = (count < QueueDepth). It does not depend on a same-cycle pop.
- Arbitration each cycle, in priority order:
  - aluValid && !aluStall: ALU wins and its result is registered to the write port.
  - Else, if the queue is non-empty: the head is popped and registered to the write port.
  - Else writeEn=0 next cycle. writeAddr/writeData hold their previous values.
- Entries pushed in cycle N are not eligible for pop until N+1.
- Simultaneous push and pop when full: the pop frees a slot only from the next cycle. memReady was already 0, so no overflow occurs.
- Scoreboard:
  - issueValid sets busyMask[issueAddr].
  - A queue pop clears busyMask[head address].
  - Same register set and cleared in one cycle: set wins, because a newer load is outstanding.
  - ALU writes never touch busyMask.
- WAW between an ALU result and a pending load to the same register is decode's responsibility. A simulation-only assertion fires on aluValid && busyMask[aluAddr].
- Queue is a circular buffer. Read and write pointers wrap modulo QueueDepth. The count is tracked separately, so full and empty are unambiguous.

## Timing
- ALU result at cycle N → writeEn=1 in cycle N+1.
- Load accepted at N with no ALU traffic → writeEn=1 in N+2. busyMask bit clears in N+2, at the same edge.
- Each cycle of ALU occupancy delays queued loads by one cycle.
- rstN asserted mid-operation: queued loads are discarded and busyMask is cleared immediately. Upstream must reissue.
- busyMask, memReady and aluStall come from flops or count only. None has a combinational path from aluValid or memValid.

## Configuration
- WB_STARVE_GUARD_EN defined:
  - A 3-bit counter increments each cycle the queue is full and the ALU wins.
  - When the counter reaches 4, aluStall=1 for the next cycle. In that cycle the queue head is popped and the counter resets.
  - The ALU must hold aluValid, aluAddr and aluData while aluStall=1.
- Undefined: counter absent. aluStall is tied 0 and the ALU can starve loads indefinitely.

## Structure
- Package wb_pkg holds a wb_entry_t struct {addr, data} and the QueueDepth default.
- One sub-module, wb_queue: parameterised circular FIFO with push/pop/full/empty/count.
- Arbitration, scoreboard and starvation counter stay in the top module.

## Test plan
- Reset: hold rstN=0 → writeEn=0, busyMask=0, memReady=1. Release, idle 3 cycles → all outputs unchanged.
- ALU only: aluValid at N with addr=3, data=0x1234 → cycle N+1 shows writeEn=1, writeAddr=3, writeData=0x1234. Cycle N+2 shows writeEn=0.
- Load path:
  - issueValid with addr=5 at N → busyMask=0x0020 at N+1.
  - Load {5, 0xBEEF} accepted at N+4 → write at N+6, busyMask=0 at N+6.
- Contention: ALU valid 4 straight cycles while two loads {1,0xAAAA} and {2,0xBBBB} arrive → memReady=0 after the second push. Loads are written in order in the two cycles after the ALU burst.
- Set/clear collision: pop of addr=7 and issueValid addr=7 in the same cycle → busyMask[7] stays 1.
- Starve guard (macro on): queue full and ALU valid continuously → aluStall=1 in the 5th cycle, one load written, ALU result held and then written in the following cycle. With the macro off, aluStall stays 0 throughout.
